mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
//  Load/store bus controller between the MIPS core datapath and the word-addressed
//  128x32 data/instruction RAM. Takes one byte/half/word request at a time and
//  converts the byte address to a word index. Drives CS/WE/ADDR and the shared
//  tri-state Mem_Bus. Performs read-modify-write for sub-word stores and
//  sign/zero extension for sub-word loads. Flags misaligned and out-of-range
//  accesses.
// PARAMETERS
//  DEPTH_WORDS  128  number of 32-bit RAM words; word index must be < DEPTH_WORDS
// PORTS
//  CLK        in     1   system clock; RAM acts on negedge, this block on posedge
//  RST_N      in     1   asynchronous active-low reset
//  REQ        in     1   core request valid; accepted on a posedge where REQ&&READY
//  READY      out    1   high only in IDLE
//  REQ_WE     in     1   1 = store, 0 = load
//  REQ_SIZE   in     2   00 byte, 01 half, 10 word, 11 illegal
//  REQ_SIGNED in     1   loads only: 1 = sign-extend, 0 = zero-extend
//  REQ_ADDR   in     32  byte address
//  REQ_WDATA  in     32  store data; byte/half taken from low bits
//  DONE       out    1   one-cycle pulse: request complete
//  ERR        out    1   valid with DONE: 1 = access rejected, no bus cycle issued
//  RDATA      out    32  load result; valid with DONE, held until the next DONE
//  CS         out    1   RAM chip select
//  WE         out    1   RAM write enable
//  ADDR       out    32  RAM word index = {2'b00, byte_addr[31:2]}
//  Mem_Bus    inout  32  driven by this block only when CS&&WE, else 'z
// BEHAVIOUR
//  - Reset: state IDLE, READY=1, DONE=0, ERR=0, RDATA=0, CS=0, WE=0, ADDR=0, Mem_Bus='z.
//  - Inputs are latched at acceptance; the core may change them afterwards.
//  - FSM states: IDLE, RD, WR, RESP.
//  - IDLE, accept, check fails (size 11; half with addr[0]!=0; word with
//    addr[1:0]!=0; addr[31:2]>=DEPTH_WORDS) -> RESP. Next cycle DONE=1, ERR=1,
//    RDATA unchanged. No CS assertion.
//  - IDLE, accept, load, or store of byte/half -> RD. Store of word -> WR.
//  - RD: CS=1, WE=0, ADDR held. The RAM updates its output at the mid-cycle negedge.
//    At the closing posedge the word on Mem_Bus is sampled.
//    Load: extract, extend into RDATA, DONE=1, -> IDLE.
//    Sub-word store: merge into the write word, -> WR.
//  - WR: CS=1, WE=1, ADDR held, Mem_Bus=merged/store word. The RAM writes at the
//    negedge. At the closing posedge: DONE=1, ERR=0, -> IDLE.
//  - RESP is used for the error path only. DONE is high in the cycle after RESP's
//    entry edge, then -> IDLE.
//  - Latency in posedges from accept to DONE asserted:
//    load 1 (DONE during cycle after RD); word store 1; sub-word store 2; error 1.
//    READY is high in the same cycle as DONE, so back-to-back requests are legal.
//  - Byte order is big-endian: byte offset 0 = bits[31:24], offset 3 = [7:0].
//    Half offset 0 = [31:16], offset 2 = [15:0].
//  - Merge replaces only the addressed byte or half with REQ_WDATA[7:0] or [15:0].
//    All other bytes keep their read value.
//  - Bus ownership: CS && !WE means the RAM drives; CS && WE means this block drives;
//    !CS means nobody drives. WE never changes while CS=1 within one state, so there
//    is no contention.
//  - CS, WE and ADDR are registered; no combinational path from REQ_* to the RAM pins.
//  - Reset asserted mid-operation forces CS=0, WE=0 and Mem_Bus='z immediately.
//    A write whose negedge has not yet occurred is abandoned. DONE is not issued.
//  - RDATA for a store is unchanged.
// TESTING
//  - Reset: hold RST_N=0 -> READY=1, CS=0, WE=0, DONE=0, Mem_Bus='z; deassert ->
//    idle, with no bus cycle.
//  - SW 0x8 data 0xDEADBEEF, then LW 0x8 -> RAM[2]=0xDEADBEEF.
//    Load DONE after 1 cycle with RDATA=0xDEADBEEF.
//  - SB 0x9 data 0x55 on RAM[2]=0xDEADBEEF -> RD then WR, RAM[2]=0xDE55BEEF,
//    DONE 2 cycles after accept.
//    Then LB signed 0x9 -> 0x00000055. LH signed 0xA -> 0xFFFFBEEF.
//    LH unsigned 0xA -> 0x0000BEEF.
//  - Errors: LW 0x6, SH 0x3, size 11, LW 0x200 -> DONE with ERR=1 each.
//    CS never asserted; RAM and RDATA unchanged.
//  - Back-to-back: REQ held high with SW 0x0, then SW 0x4, then LW 0x0.
//    One DONE per request; READY drops outside IDLE; final RDATA is the first
//    store's data.
//  - Reset mid-WR: assert RST_N=0 before the negedge of a SW 0xC.
//    RAM[3] is unchanged, CS=0 and WE=0 immediately, and no DONE is issued.

Source files
------------

// File: rtl/mem_bus_ctrl_if.sv
// Core-side request/response bundle for the load/store bus controller.
// The core is the master; the controller is the slave.
interface mem_bus_ctrl_if;
  logic        REQ;
  logic        READY;
  logic        REQ_WE;
  logic [1:0]  REQ_SIZE;
  logic        REQ_SIGNED;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        DONE;
  logic        ERR;
  logic [31:0] RDATA;

  modport master (
    output REQ, REQ_WE, REQ_SIZE, REQ_SIGNED,
    output REQ_ADDR, REQ_WDATA,
    input  READY, DONE, ERR, RDATA
  );

  modport slave (
    input  REQ, REQ_WE, REQ_SIZE, REQ_SIGNED,
    input  REQ_ADDR, REQ_WDATA,
    output READY, DONE, ERR, RDATA
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Load/store controller for a word-addressed 32-bit RAM on a shared
// tri-state bus: sub-word read-modify-write, load extension, access checks.
module mem_bus_ctrl #(
  parameter int DEPTH_WORDS = 128
) (
  input  logic          CLK,
  input  logic          RST_N,
  mem_bus_ctrl_if.slave bus,
  output logic          CS,
  output logic          WE,
  output logic [31:0]   ADDR,
  inout  wire  [31:0]   Mem_Bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [29:0] LIMIT = 30'(DEPTH_WORDS);

  state_t      state, state_n;
  logic        cs_n, we_n;
  logic [31:0] addr_n;
  logic        done, done_n;
  logic        err, err_n;
  logic [31:0] rdata, rdata_n;
  logic [31:0] wword, wword_n;
  logic        st, st_n;
  logic [1:0]  sz, sz_n;
  logic [1:0]  off, off_n;
  logic        sg, sg_n;
  logic        bad;

  // Big-endian lanes: offset 0 is the most significant byte.
  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [1:0]  size,
    input logic [1:0]  o,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (o)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = o[1] ? w[15:0] : w[31:16];
    unique case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [31:0] d,
    input logic [1:0]  size,
    input logic [1:0]  o
  );
    logic [31:0] m;
    m = w;
    if (size == 2'b00) begin
      unique case (o)
        2'd0:    m[31:24] = d[7:0];
        2'd1:    m[23:16] = d[7:0];
        2'd2:    m[15:8]  = d[7:0];
        default: m[7:0]   = d[7:0];
      endcase
    end else if (o[1]) begin
      m[15:0] = d[15:0];
    end else begin
      m[31:16] = d[15:0];
    end
    return m;
  endfunction

  always_comb begin
    bad = 1'b0;
    unique case (bus.REQ_SIZE)
      2'b11:   bad = 1'b1;
      2'b01:   bad = bus.REQ_ADDR[0];
      2'b10:   bad = |bus.REQ_ADDR[1:0];
      default: bad = 1'b0;
    endcase
    if (bus.REQ_ADDR[31:2] >= LIMIT) bad = 1'b1;
  end

  always_comb begin
    state_n = state;
    cs_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = ADDR;
    done_n  = 1'b0;
    err_n   = 1'b0;
    rdata_n = rdata;
    wword_n = wword;
    st_n    = st;
    sz_n    = sz;
    off_n   = off;
    sg_n    = sg;
    unique case (state)
      IDLE: begin
        if (bus.REQ) begin
          st_n    = bus.REQ_WE;
          sz_n    = bus.REQ_SIZE;
          off_n   = bus.REQ_ADDR[1:0];
          sg_n    = bus.REQ_SIGNED;
          wword_n = bus.REQ_WDATA;
          if (bad) begin
            state_n = RESP;
          end else begin
            addr_n = {2'b00, bus.REQ_ADDR[31:2]};
            cs_n   = 1'b1;
            if (bus.REQ_WE && bus.REQ_SIZE == 2'b10) begin
              state_n = WR;
              we_n    = 1'b1;
            end else begin
              state_n = RD;
            end
          end
        end
      end
      RD: begin
        if (st) begin
          wword_n = merge(Mem_Bus, wword, sz, off);
          state_n = WR;
          cs_n    = 1'b1;
          we_n    = 1'b1;
        end else begin
          rdata_n = load_ext(Mem_Bus, sz, off, sg);
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      WR: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      RESP: begin
        done_n  = 1'b1;
        err_n   = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      CS    <= 1'b0;
      WE    <= 1'b0;
      ADDR  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      wword <= '0;
      st    <= 1'b0;
      sz    <= '0;
      off   <= '0;
      sg    <= 1'b0;
    end else begin
      state <= state_n;
      CS    <= cs_n;
      WE    <= we_n;
      ADDR  <= addr_n;
      done  <= done_n;
      err   <= err_n;
      rdata <= rdata_n;
      wword <= wword_n;
      st    <= st_n;
      sz    <= sz_n;
      off   <= off_n;
      sg    <= sg_n;
    end
  end

  assign Mem_Bus   = (CS && WE) ? wword : 'z;
  assign bus.READY = (state == IDLE);
  assign bus.DONE  = done;
  assign bus.ERR   = err;
  assign bus.RDATA = rdata;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl with a negedge RAM model
// sharing the tri-state bus.
module tb_mem_bus_ctrl;
  logic        CLK;
  logic        RST_N;
  logic        CS;
  logic        WE;
  logic [31:0] ADDR;
  wire  [31:0] mem_bus;

  mem_bus_ctrl_if bus ();

  mem_bus_ctrl #(.DEPTH_WORDS(128)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .bus     (bus),
    .CS      (CS),
    .WE      (WE),
    .ADDR    (ADDR),
    .Mem_Bus (mem_bus)
  );

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ram [128];
  logic [31:0] ram_q;
  int          cyc;
  int          cs_cnt;
  int          n_chk;
  int          n_fail;
  logic [31:0] last_rd;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial cs_cnt = 0;
  always @(negedge CLK) if (CS) cs_cnt <= cs_cnt + 1;

  // RAM acts on the falling edge, mid-cycle.
  initial begin
    for (int i = 0; i < 128; i++) ram[i] = 32'hA000_0000 | i;
    ram_q = '0;
    forever begin
      @(negedge CLK);
      if (CS) begin
        if (WE) ram[ADDR[6:0]] = mem_bus;
        else    ram_q = ram[ADDR[6:0]];
      end
    end
  end

  assign mem_bus = (CS && !WE) ? ram_q : 'z;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (bus.DONE) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected DONE: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          chk({e.name, " err"}, {31'd0, bus.ERR}, {31'd0, e.err});
          chk({e.name, " rdata"}, bus.RDATA, e.rdata);
          chk({e.name, " latency"}, cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic send(input string nm, input bit we, input bit [1:0] sz,
                      input bit sg, input bit [31:0] a, input bit [31:0] d,
                      input bit er, input bit [31:0] rd, input int lat,
                      input bit hold);
    exp_t e;
    int   t;
    t = 0;
    while (!bus.READY && t < 20) begin
      @(posedge CLK); #1;
      t++;
    end
    chk({nm, " ready wait"}, {31'd0, bus.READY}, 32'd1);
    bus.REQ_WE     = we;
    bus.REQ_SIZE   = sz;
    bus.REQ_SIGNED = sg;
    bus.REQ_ADDR   = a;
    bus.REQ_WDATA  = d;
    bus.REQ        = 1'b1;
    if (!we && !er) last_rd = rd;
    e.name  = nm;
    e.err   = er;
    e.rdata = last_rd;
    e.lat   = lat;
    e.acc   = cyc + 1;
    q.push_back(e);
    @(posedge CLK); #1;
    chk({nm, " ready low"}, {31'd0, bus.READY}, 32'd0);
    if (!hold) begin
      bus.REQ = 1'b0;
      t = 0;
      while (q.size() != 0 && t < 10) begin
        @(posedge CLK); #1;
        t++;
      end
      chk({nm, " drained"}, 32'(q.size()), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs0;
    n_chk   = 0;
    n_fail  = 0;
    last_rd = '0;
    RST_N   = 1'b0;
    bus.REQ = 1'b0;
    bus.REQ_WE = 1'b0;
    bus.REQ_SIZE = 2'b00;
    bus.REQ_SIGNED = 1'b0;
    bus.REQ_ADDR = '0;
    bus.REQ_WDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst ready", {31'd0, bus.READY}, 32'd1);
    chk("rst cs", {31'd0, CS}, 32'd0);
    chk("rst we", {31'd0, WE}, 32'd0);
    chk("rst done", {31'd0, bus.DONE}, 32'd0);
    chk("rst err", {31'd0, bus.ERR}, 32'd0);
    chk("rst rdata", bus.RDATA, 32'd0);
    chk("rst addr", ADDR, 32'd0);
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("idle cs", {31'd0, CS}, 32'd0);
    chk("idle cs count", cs_cnt, 0);

    send("SW 0x8", 1, 2'b10, 0, 32'h8, 32'hDEADBEEF, 0, 0, 1, 0);
    chk("ram2 after SW", ram[2], 32'hDEADBEEF);
    send("LW 0x8", 0, 2'b10, 0, 32'h8, 0, 0, 32'hDEADBEEF, 1, 0);
    send("SB 0x9", 1, 2'b00, 0, 32'h9, 32'hFFFFFF55, 0, 0, 2, 0);
    chk("ram2 after SB", ram[2], 32'hDE55BEEF);
    send("LB s 0x9", 0, 2'b00, 1, 32'h9, 0, 0, 32'h00000055, 1, 0);
    send("LH s 0xA", 0, 2'b01, 1, 32'hA, 0, 0, 32'hFFFFBEEF, 1, 0);
    send("LH u 0xA", 0, 2'b01, 0, 32'hA, 0, 0, 32'h0000BEEF, 1, 0);
    send("LB s 0x8", 0, 2'b00, 1, 32'h8, 0, 0, 32'hFFFFFFDE, 1, 0);
    send("LB u 0xB", 0, 2'b00, 0, 32'hB, 0, 0, 32'h000000EF, 1, 0);
    send("SH 0xA", 1, 2'b01, 0, 32'hA, 32'hABCD1234, 0, 0, 2, 0);
    chk("ram2 after SH", ram[2], 32'hDE551234);
    send("LW 0x8 b", 0, 2'b10, 0, 32'h8, 0, 0, 32'hDE551234, 1, 0);

    cs0 = cs_cnt;
    send("LW 0x6", 0, 2'b10, 0, 32'h6, 0, 1, 0, 1, 0);
    send("SH 0x3", 1, 2'b01, 0, 32'h3, 32'h7777, 1, 0, 1, 0);
    send("size 11", 0, 2'b11, 0, 32'h0, 0, 1, 0, 1, 0);
    send("LW 0x200", 0, 2'b10, 0, 32'h200, 0, 1, 0, 1, 0);
    chk("err no cs", cs_cnt, cs0);
    chk("err ram2", ram[2], 32'hDE551234);
    chk("err ram0", ram[0], 32'hA0000000);

    send("b2b SW 0x0", 1, 2'b10, 0, 32'h0, 32'h11111111, 0, 0, 1, 1);
    send("b2b SW 0x4", 1, 2'b10, 0, 32'h4, 32'h22222222, 0, 0, 1, 1);
    send("b2b LW 0x0", 0, 2'b10, 0, 32'h0, 0, 0, 32'h11111111, 1, 0);
    chk("b2b ram1", ram[1], 32'h22222222);

    @(posedge CLK); #1;
    bus.REQ_WE    = 1'b1;
    bus.REQ_SIZE  = 2'b10;
    bus.REQ_ADDR  = 32'hC;
    bus.REQ_WDATA = 32'h12345678;
    bus.REQ       = 1'b1;
    @(posedge CLK); #1;
    chk("midwr cs before", {31'd0, CS}, 32'd1);
    bus.REQ = 1'b0;
    RST_N   = 1'b0;
    #1;
    chk("midwr cs", {31'd0, CS}, 32'd0);
    chk("midwr we", {31'd0, WE}, 32'd0);
    chk("midwr ready", {31'd0, bus.READY}, 32'd1);
    repeat (2) @(posedge CLK);
    #1;
    chk("midwr ram3", ram[3], 32'hA0000003);
    chk("midwr rdata", bus.RDATA, 32'd0);
    RST_N   = 1'b1;
    last_rd = '0;
    repeat (2) @(posedge CLK);
    #1;
    send("LW 0xC", 0, 2'b10, 0, 32'hC, 0, 0, 32'hA0000003, 1, 0);

    repeat (3) @(posedge CLK);
    #1;
    chk("final queue", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
